uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_pkg.sv | 29 ++
 rtl/uart_cmd_timeout.sv | 41 ++++
 rtl/uart_cmd_parser.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared definitions for the UART command parser: frame FSM
//               state encodings, error-code constants and the default
//               frame start marker.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  // One state per expected frame byte; the state names the byte awaited next.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ID     = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA_H = 3'd3,
    S_DATA_L = 3'd4,
    S_CHK    = 3'd5
  } state_t;

  localparam logic [1:0] c_err_none     = 2'b00;
  localparam logic [1:0] c_err_checksum = 2'b01;
  localparam logic [1:0] c_err_overflow = 2'b10;
  localparam logic [1:0] c_err_timeout  = 2'b11;

  localparam logic [7:0] c_sync_byte_default = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_timeout.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_timeout
// Description : 16-bit inter-byte watchdog. The count is cleared by i_Clear
//               and held at zero while i_Enable is low; o_Expire is raised
//               while enabled and the count has reached TIMEOUT_CLKS-1.
// Ports       : i_Clock  - clock, rising edge
//               i_Reset  - asynchronous active-high reset
//               i_Clear  - restart the count (a byte arrived)
//               i_Enable - count while a frame is in progress
//               o_Expire - timeout reached
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CLKS = 52080
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expire
);

  localparam logic [15:0] c_limit = 16'(TIMEOUT_CLKS - 1);

  logic [15:0] r_count;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_count <= 16'd0;
    end else if (i_Clear || !i_Enable) begin
      r_count <= 16'd0;
    end else if (r_count != c_limit) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_Expire = i_Enable && (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Parses six-byte command frames (SYNC, ID, ADDR, DATA_H,
//               DATA_L, CHK with CHK = ID^ADDR^DATA_H^DATA_L) from a UART
//               receiver byte stream into a one-deep command holding
//               register with a valid/ready handshake. Reports checksum,
//               overflow and (optionally) inter-byte timeout errors.
// Config      : define UART_CMD_TIMEOUT_EN to build the inter-byte timeout;
//               without it a partial frame waits indefinitely.
// Ports       : i_Clock      - clock, rising edge
//               i_Reset      - asynchronous active-high reset
//               i_Rx_DV      - received byte strobe
//               i_Rx_Byte    - received byte
//               i_Cmd_Ready  - consumer accepts the held command
//               o_Cmd_Valid  - holding register full
//               o_Cmd_Id     - command ID
//               o_Cmd_Addr   - target address
//               o_Cmd_Data   - {DATA_H, DATA_L}
//               o_Err_Pulse  - one-cycle error strobe
//               o_Err_Code   - last error (00 none/01 chk/10 ovf/11 timeout)
//               o_Err_Count  - saturating error count
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = c_sync_byte_default,
  parameter int unsigned TIMEOUT_CLKS = 52080
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic        i_Cmd_Ready,
  output logic        o_Cmd_Valid,
  output logic [7:0]  o_Cmd_Id,
  output logic [7:0]  o_Cmd_Addr,
  output logic [15:0] o_Cmd_Data,
  output logic        o_Err_Pulse,
  output logic [1:0]  o_Err_Code,
  output logic [7:0]  o_Err_Count
);

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_xor;
  logic [7:0]  r_id_buf;
  logic [7:0]  r_addr_buf;
  logic [7:0]  r_data_h_buf;
  logic [7:0]  r_data_l_buf;

  logic        r_cmd_valid;
  logic [7:0]  r_cmd_id;
  logic [7:0]  r_cmd_addr;
  logic [15:0] r_cmd_data;

  logic        r_err_pulse;
  logic [1:0]  r_err_code;
  logic [7:0]  r_err_count;

  logic        w_timeout;
  logic        w_chk_done;
  logic        w_chk_ok;
  logic        w_slot_free;
  logic        w_load;
  logic        w_err;
  logic [1:0]  w_err_code;

`ifdef UART_CMD_TIMEOUT_EN
  logic w_expire;

  uart_cmd_timeout #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (i_Rx_DV),
    .i_Enable (r_state != S_IDLE),
    .o_Expire (w_expire)
  );

  // An arriving byte always wins over a simultaneous expiry.
  assign w_timeout = w_expire && !i_Rx_DV;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CLKS;
  assign w_timeout        = 1'b0;
`endif

  // Frame completion: the slot is free if empty or being drained this cycle.
  assign w_chk_done  = i_Rx_DV && (r_state == S_CHK);
  assign w_chk_ok    = (i_Rx_Byte == r_xor);
  assign w_slot_free = !r_cmd_valid || i_Cmd_Ready;
  assign w_load      = w_chk_done && w_chk_ok && w_slot_free;

  always_comb begin
    w_err      = 1'b0;
    w_err_code = c_err_none;
    if (w_chk_done && !w_chk_ok) begin
      w_err      = 1'b1;
      w_err_code = c_err_checksum;
    end else if (w_chk_done && !w_slot_free) begin
      w_err      = 1'b1;
      w_err_code = c_err_overflow;
    end else if (w_timeout) begin
      w_err      = 1'b1;
      w_err_code = c_err_timeout;
    end
  end

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_Rx_DV) begin
      case (r_state)
        S_IDLE:   w_state_next = (i_Rx_Byte == SYNC_BYTE) ? S_ID : S_IDLE;
        S_ID:     w_state_next = S_ADDR;
        S_ADDR:   w_state_next = S_DATA_H;
        S_DATA_H: w_state_next = S_DATA_L;
        S_DATA_L: w_state_next = S_CHK;
        S_CHK:    w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_next = S_IDLE;
    end
  end

  // --------------------------------------------------- byte capture ------
  // A SYNC value seen outside S_IDLE is ordinary payload.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_xor        <= 8'd0;
      r_id_buf     <= 8'd0;
      r_addr_buf   <= 8'd0;
      r_data_h_buf <= 8'd0;
      r_data_l_buf <= 8'd0;
    end else if (i_Rx_DV) begin
      case (r_state)
        S_IDLE: begin
          if (i_Rx_Byte == SYNC_BYTE) begin
            r_xor <= 8'd0;
          end
        end
        S_ID: begin
          r_id_buf <= i_Rx_Byte;
          r_xor    <= r_xor ^ i_Rx_Byte;
        end
        S_ADDR: begin
          r_addr_buf <= i_Rx_Byte;
          r_xor      <= r_xor ^ i_Rx_Byte;
        end
        S_DATA_H: begin
          r_data_h_buf <= i_Rx_Byte;
          r_xor        <= r_xor ^ i_Rx_Byte;
        end
        S_DATA_L: begin
          r_data_l_buf <= i_Rx_Byte;
          r_xor        <= r_xor ^ i_Rx_Byte;
        end
        default: begin
        end
      endcase
    end
  end

  // ------------------------------------------------ holding register -----
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd_id    <= 8'd0;
      r_cmd_addr  <= 8'd0;
      r_cmd_data  <= 16'd0;
    end else if (w_load) begin
      r_cmd_valid <= 1'b1;
      r_cmd_id    <= r_id_buf;
      r_cmd_addr  <= r_addr_buf;
      r_cmd_data  <= {r_data_h_buf, r_data_l_buf};
    end else if (r_cmd_valid && i_Cmd_Ready) begin
      r_cmd_valid <= 1'b0;
    end
  end

  // ------------------------------------------------- error reporting -----
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_err_pulse <= 1'b0;
      r_err_code  <= c_err_none;
      r_err_count <= 8'd0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err) begin
        r_err_code <= w_err_code;
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end
    end
  end

  assign o_Cmd_Valid = r_cmd_valid;
  assign o_Cmd_Id    = r_cmd_id;
  assign o_Cmd_Addr  = r_cmd_addr;
  assign o_Cmd_Data  = r_cmd_data;
  assign o_Err_Pulse = r_err_pulse;
  assign o_Err_Code  = r_err_code;
  assign o_Err_Count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Self-checking bench for uart_cmd_parser. A frame-level
//               reference model pushes expected commands and errors into
//               queues; a monitor pops and compares them when the DUT
//               hands a command over or pulses an error. Directed frames
//               are followed by randomized traffic and random back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

  localparam int unsigned T    = 52080;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        drv_dv;
  logic [7:0]  drv_byte;
  logic        drv_ready;
  logic        rand_ready;

  logic        o_Cmd_Valid;
  logic [7:0]  o_Cmd_Id;
  logic [7:0]  o_Cmd_Addr;
  logic [15:0] o_Cmd_Data;
  logic        o_Err_Pulse;
  logic [1:0]  o_Err_Code;
  logic [7:0]  o_Err_Count;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .SYNC_BYTE    (SYNC),
    .TIMEOUT_CLKS (T)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Rx_DV     (drv_dv),
    .i_Rx_Byte   (drv_byte),
    .i_Cmd_Ready (drv_ready),
    .o_Cmd_Valid (o_Cmd_Valid),
    .o_Cmd_Id    (o_Cmd_Id),
    .o_Cmd_Addr  (o_Cmd_Addr),
    .o_Cmd_Data  (o_Cmd_Data),
    .o_Err_Pulse (o_Err_Pulse),
    .o_Err_Code  (o_Err_Code),
    .o_Err_Count (o_Err_Count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // ------------------------------------------------ reference model ------
  // Frame-level view: collect bytes after SYNC, judge the frame on byte 6.
  logic [31:0] exp_cmd_q[$];
  logic [9:0]  exp_err_q[$];

  int          m_nbytes;      // bytes of the current frame seen after SYNC
  logic [7:0]  m_frame[4];
  logic        m_valid;
  logic        m_pulse;
  logic [1:0]  m_code;
  logic [7:0]  m_count;
  int unsigned m_quiet;       // clocks without a byte inside a frame

  task automatic model_reset();
    m_nbytes = 0;
    m_valid  = 1'b0;
    m_pulse  = 1'b0;
    m_code   = 2'b00;
    m_count  = 8'd0;
    m_quiet  = 0;
    exp_cmd_q.delete();
    exp_err_q.delete();
  endtask

  task automatic model_error(input logic [1:0] code);
    m_pulse = 1'b1;
    m_code  = code;
    if (m_count < 8'd255) m_count = m_count + 8'd1;
    exp_err_q.push_back({code, m_count});
  endtask

  task automatic model_step();
    logic drained;
    logic loaded;
    drained = m_valid && drv_ready;
    loaded  = 1'b0;
    m_pulse = 1'b0;
    if (drv_dv) begin
      m_quiet = 0;
      if (m_nbytes == 0 && drv_byte == SYNC) begin
        m_nbytes = 1;
      end else if (m_nbytes >= 1 && m_nbytes <= 4) begin
        m_frame[m_nbytes-1] = drv_byte;
        m_nbytes++;
      end else if (m_nbytes == 5) begin
        m_nbytes = 0;
        if (drv_byte != (m_frame[0] ^ m_frame[1] ^ m_frame[2] ^ m_frame[3])) begin
          model_error(2'b01);
        end else if (m_valid && !drv_ready) begin
          model_error(2'b10);
        end else begin
          loaded = 1'b1;
          exp_cmd_q.push_back({m_frame[0], m_frame[1], m_frame[2], m_frame[3]});
        end
      end
    end
`ifdef UART_CMD_TIMEOUT_EN
    else if (m_nbytes != 0) begin
      if (m_quiet == T - 1) begin
        m_nbytes = 0;
        m_quiet  = 0;
        model_error(2'b11);
      end else begin
        m_quiet++;
      end
    end
`endif
    if (loaded) m_valid = 1'b1;
    else if (drained) m_valid = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst) model_step();
  end

  // ------------------------------------------------------- monitor -------
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("cmd_valid", 64'(o_Cmd_Valid), 64'(m_valid));
      check("err_state", 64'({o_Err_Pulse, o_Err_Code, o_Err_Count}),
            64'({m_pulse, m_code, m_count}));
      if (o_Cmd_Valid && drv_ready) begin
        if (exp_cmd_q.size() == 0) check("cmd_unexpected", 64'(1), 64'(0));
        else check("cmd_fields", 64'({o_Cmd_Id, o_Cmd_Addr, o_Cmd_Data}),
                   64'(exp_cmd_q.pop_front()));
      end
      if (o_Err_Pulse) begin
        if (exp_err_q.size() == 0) check("err_unexpected", 64'(1), 64'(0));
        else check("err_event", 64'({o_Err_Code, o_Err_Count}),
                   64'(exp_err_q.pop_front()));
      end
    end
  end

  // ------------------------------------------------------ stimulus -------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) drv_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    drv_byte = b;
    drv_dv   = 1'b1;
    tick();
    drv_dv   = 1'b0;
    drv_byte = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [7:0] addr,
                            input logic [7:0] dh, input logic [7:0] dl,
                            input logic [7:0] chk);
    send_byte(SYNC);
    send_byte(id);
    send_byte(addr);
    send_byte(dh);
    send_byte(dl);
    send_byte(chk);
  endtask

  function automatic logic [43:0] all_outputs();
    return {o_Cmd_Valid, o_Cmd_Id, o_Cmd_Addr, o_Cmd_Data,
            o_Err_Pulse, o_Err_Code, o_Err_Count};
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_async", 64'(all_outputs()), 64'(0));
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] id, addr, dh, dl, chk;
    int         kind;
    rst        = 1'b1;
    drv_dv     = 1'b0;
    drv_byte   = 8'h00;
    drv_ready  = 1'b0;
    rand_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'(all_outputs()), 64'(0));
    rst = 1'b0;
    tick();

    // Good frame, one-cycle latency
    send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37);
    check("good_valid", 64'(o_Cmd_Valid), 64'(1));
    check("good_fields", 64'({o_Cmd_Id, o_Cmd_Addr, o_Cmd_Data}), 64'(32'h0110_1234));
    check("good_no_err", 64'({o_Err_Pulse, o_Err_Code, o_Err_Count}), 64'(0));
    drain();
    check("accept_clears", 64'(o_Cmd_Valid), 64'(0));

    // Checksum error
    send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h36);
    check("chk_pulse", 64'(o_Err_Pulse), 64'(1));
    check("chk_code_count", 64'({o_Err_Code, o_Err_Count}), 64'({2'b01, 8'd1}));
    check("chk_no_valid", 64'(o_Cmd_Valid), 64'(0));
    tick();
    check("chk_pulse_width", 64'({o_Err_Pulse, o_Err_Code}), 64'({1'b0, 2'b01}));

    // Junk in idle then a good frame
    apply_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("junk_silent", 64'({o_Cmd_Valid, o_Err_Pulse, o_Err_Code, o_Err_Count}), 64'(0));
    send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37);
    check("after_junk_fields", 64'({o_Cmd_Valid, o_Cmd_Id, o_Cmd_Addr, o_Cmd_Data}),
          64'({1'b1, 32'h0110_1234}));
    check("after_junk_count", 64'(o_Err_Count), 64'(0));
    drain();

    // Overflow: second frame dropped while first is held
    send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37);
    send_frame(8'h02, 8'h10, 8'h12, 8'h34, 8'h34);
    check("ovf_code", 64'({o_Err_Pulse, o_Err_Code, o_Err_Count}), 64'({1'b1, 2'b10, 8'd1}));
    check("ovf_held", 64'({o_Cmd_Valid, o_Cmd_Id, o_Cmd_Addr, o_Cmd_Data}),
          64'({1'b1, 32'h0110_1234}));
    drain();
    check("ovf_ready_clears", 64'(o_Cmd_Valid), 64'(0));

    // Load in the same cycle as an accept keeps valid high, no error
    send_frame(8'h03, 8'h20, 8'hAB, 8'hCD, 8'h03 ^ 8'h20 ^ 8'hAB ^ 8'hCD);
    send_byte(SYNC);
    send_byte(8'h04);
    send_byte(8'h21);
    send_byte(8'h00);
    send_byte(8'h01);
    drv_ready = 1'b1;
    send_byte(8'h04 ^ 8'h21 ^ 8'h00 ^ 8'h01);
    drv_ready = 1'b0;
    check("swap_fields", 64'({o_Cmd_Valid, o_Cmd_Id, o_Cmd_Addr, o_Cmd_Data}),
          64'({1'b1, 32'h0421_0001}));
    check("swap_no_err", 64'({o_Err_Pulse, o_Err_Count}), 64'(8'd1));
    drain();

    // Reset mid-frame abandons it
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h10);
    apply_reset();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h37);
    check("post_reset_quiet", 64'(all_outputs()), 64'(0));

`ifdef UART_CMD_TIMEOUT_EN
    // Inter-byte timeout
    begin
      bit seen;
      seen = 1'b0;
      send_byte(SYNC);
      send_byte(8'h01);
      for (int i = 0; i < int'(T) + 16 && !seen; i++) begin
        tick();
        if (o_Err_Pulse) seen = 1'b1;
      end
      check("timeout_seen", 64'(seen), 64'(1));
      check("timeout_code", 64'(o_Err_Code), 64'(2'b11));
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37);
      check("after_timeout_fields", 64'({o_Cmd_Valid, o_Cmd_Id, o_Cmd_Addr, o_Cmd_Data}),
            64'({1'b1, 32'h0110_1234}));
      drain();
    end
`endif

    // Randomized traffic with random back-pressure
    rand_ready = 1'b1;
    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 9);
      id   = 8'($urandom);
      addr = 8'($urandom);
      dh   = 8'($urandom);
      dl   = 8'($urandom);
      chk  = id ^ addr ^ dh ^ dl;
      if (kind < 5) begin
        send_frame(id, addr, dh, dl, chk);
      end else if (kind < 7) begin
        send_frame(id, addr, dh, dl, chk ^ 8'($urandom_range(1, 255)));
      end else if (kind < 9) begin
        repeat ($urandom_range(1, 3)) send_byte(8'($urandom_range(0, 8'hA4)));
      end else begin
        send_byte(SYNC);
        repeat ($urandom_range(1, 4)) send_byte(8'($urandom));
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_ready = 1'b0;
    drv_ready  = 1'b1;
    repeat (8) tick();
    check("cmd_queue_empty", 64'(exp_cmd_q.size()), 64'(0));
    check("err_queue_empty", 64'(exp_err_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
